// File: rtl/multi_port_regfile_pkg.sv
// Shared defaults and index type for the multi-port register file.
package multi_port_regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NR_RD_DEF  = 2;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/multi_port_regfile_if.sv
// Bus bundle for the register file: read ports, two write ports, issue and debug.
interface multi_port_regfile_if
  import multi_port_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NR_RD  = NR_RD_DEF
) ();

  logic [NR_RD*ADDR_W-1:0] rf_ra;
  logic [NR_RD*DATA_W-1:0] rf_rd;
  logic [NR_RD-1:0]        rf_busy;
  logic                    rf_we0;
  logic [ADDR_W-1:0]       rf_wa0;
  logic [DATA_W-1:0]       rf_wd0;
  logic                    rf_we1;
  logic [ADDR_W-1:0]       rf_wa1;
  logic [DATA_W-1:0]       rf_wd1;
  logic                    iss_valid;
  logic [ADDR_W-1:0]       iss_wa;
  logic [ADDR_W-1:0]       dbg_rf_ra;
  logic [DATA_W-1:0]       dbg_rf_rd;
  logic [ADDR_W:0]         busy_cnt;

  modport master (
    output rf_ra, rf_we0, rf_wa0, rf_wd0, rf_we1, rf_wa1, rf_wd1,
           iss_valid, iss_wa, dbg_rf_ra,
    input  rf_rd, rf_busy, dbg_rf_rd, busy_cnt
  );

  modport slave (
    input  rf_ra, rf_we0, rf_wa0, rf_wd0, rf_we1, rf_wa1, rf_wd1,
           iss_valid, iss_wa, dbg_rf_ra,
    output rf_rd, rf_busy, dbg_rf_rd, busy_cnt
  );

endinterface

// File: rtl/multi_port_regfile_scoreboard.sv
// rf_scoreboard: per-register busy bits with a registered population count.
module rf_scoreboard
  import multi_port_regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   we0,
  input  logic [ADDR_W-1:0]      wa0,
  input  logic                   we1,
  input  logic [ADDR_W-1:0]      wa1,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_wa,
  output logic [2**ADDR_W-1:0]   busy,
  output logic [ADDR_W:0]        busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_nxt;
  logic [ADDR_W:0]  cnt_nxt;

  // Clears first, then the issue set, so a same-cycle set wins.
  always_comb begin
    busy_nxt = busy;
    if (we0 && wa0 != '0) busy_nxt[wa0] = 1'b0;
    if (we1 && wa1 != '0) busy_nxt[wa1] = 1'b0;
    if (iss_valid && iss_wa != '0) busy_nxt[iss_wa] = 1'b1;
    cnt_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/multi_port_regfile.sv
// Multi-port register file with two write ports, busy scoreboard and debug read.
// Optional same-cycle write-to-read forwarding under `define RF_BYPASS_EN.
module multi_port_regfile
  import multi_port_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NR_RD  = NR_RD_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  multi_port_regfile_if.slave rf
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]       regs [DEPTH];
  logic [DEPTH-1:0]        busy_vec;
  logic [NR_RD*DATA_W-1:0] rd_pk;
  logic [NR_RD-1:0]        busy_pk;

  rf_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk       (clk),
    .rstn      (rstn),
    .we0       (rf.rf_we0),
    .wa0       (rf.rf_wa0),
    .we1       (rf.rf_we1),
    .wa1       (rf.rf_wa1),
    .iss_valid (rf.iss_valid),
    .iss_wa    (rf.iss_wa),
    .busy      (busy_vec),
    .busy_cnt  (rf.busy_cnt)
  );

  // Port 1 is the younger instruction, so its write lands last.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (rf.rf_we0 && rf.rf_wa0 != '0) regs[rf.rf_wa0] <= rf.rf_wd0;
      if (rf.rf_we1 && rf.rf_wa1 != '0) regs[rf.rf_wa1] <= rf.rf_wd1;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_k;
    logic              bsy_k;
    rd_pk   = '0;
    busy_pk = '0;
    for (int unsigned k = 0; k < NR_RD; k++) begin
      ra    = rf.rf_ra[k*ADDR_W +: ADDR_W];
      rd_k  = regs[ra];
      bsy_k = busy_vec[ra];
`ifdef RF_BYPASS_EN
      if (rstn && ra != '0) begin
        if (rf.rf_we1 && rf.rf_wa1 == ra) begin
          rd_k  = rf.rf_wd1;
          bsy_k = rf.iss_valid && rf.iss_wa == ra;
        end else if (rf.rf_we0 && rf.rf_wa0 == ra) begin
          rd_k  = rf.rf_wd0;
          bsy_k = rf.iss_valid && rf.iss_wa == ra;
        end
      end
`endif
      rd_pk[k*DATA_W +: DATA_W] = rd_k;
      busy_pk[k]                = bsy_k;
    end
  end

  assign rf.rf_rd     = rd_pk;
  assign rf.rf_busy   = busy_pk;
  assign rf.dbg_rf_rd = regs[rf.dbg_rf_ra];

endmodule

// File: tb/tb_multi_port_regfile.sv
// Randomized and directed checks of multi_port_regfile against an array-based model.
module tb_multi_port_regfile;
  import multi_port_regfile_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 2**AW;

  logic clk;
  logic rstn;

  multi_port_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NR_RD(NR)) bus ();

  multi_port_regfile #(.DATA_W(DW), .ADDR_W(AW), .NR_RD(NR)) dut (
    .clk  (clk),
    .rstn (rstn),
    .rf   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem  [DEPTH];
  bit            busy [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (busy[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = '0;
      busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    bus.rf_we0 = 1'b0; bus.rf_wa0 = '0; bus.rf_wd0 = '0;
    bus.rf_we1 = 1'b0; bus.rf_wa1 = '0; bus.rf_wd1 = '0;
    bus.iss_valid = 1'b0; bus.iss_wa = '0;
  endtask

  task automatic set_ra_all(input reg_idx_t a);
    for (int k = 0; k < NR; k++) bus.rf_ra[k*AW +: AW] = a;
  endtask

  // Entered at posedge+1 with inputs driven; leaves at the next posedge+1.
  task automatic cycle();
    logic [AW-1:0] a;
    logic [DW-1:0] e;
    logic          eb;
    if (!rstn) model_reset();
    #3;
    for (int k = 0; k < NR; k++) begin
      a  = bus.rf_ra[k*AW +: AW];
      e  = (a == 0) ? '0 : mem[a];
      eb = busy[a];
`ifdef RF_BYPASS_EN
      if (rstn && a != 0) begin
        if (bus.rf_we1 && bus.rf_wa1 == a) begin
          e  = bus.rf_wd1;
          eb = bus.iss_valid && bus.iss_wa == a;
        end else if (bus.rf_we0 && bus.rf_wa0 == a) begin
          e  = bus.rf_wd0;
          eb = bus.iss_valid && bus.iss_wa == a;
        end
      end
`endif
      chk("rf_rd", bus.rf_rd[k*DW +: DW], e);
      chk("rf_busy", bus.rf_busy[k], eb);
    end
    chk("dbg_rf_rd", bus.dbg_rf_rd, mem[bus.dbg_rf_ra]);
    chk("busy_cnt", bus.busy_cnt, model_cnt());
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else begin
      if (bus.rf_we0 && bus.rf_wa0 != 0) begin mem[bus.rf_wa0] = bus.rf_wd0; busy[bus.rf_wa0] = 0; end
      if (bus.rf_we1 && bus.rf_wa1 != 0) begin mem[bus.rf_wa1] = bus.rf_wd1; busy[bus.rf_wa1] = 0; end
      if (bus.iss_valid && bus.iss_wa != 0) busy[bus.iss_wa] = 1;
    end
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    bus.rf_ra = '0;
    bus.dbg_rf_ra = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset state
    set_ra_all(5'd3);
    bus.dbg_rf_ra = 5'd3;
    #1;
    chk("reset_rd", bus.rf_rd, '0);
    chk("reset_busy", bus.rf_busy, '0);
    chk("reset_dbg", bus.dbg_rf_rd, '0);
    chk("reset_cnt", bus.busy_cnt, '0);
    cycle();
    rstn = 1'b1;
    cycle();

    // Register 0 is never written nor busy
    bus.rf_we0 = 1; bus.rf_wa0 = 0; bus.rf_wd0 = 32'hFFFF_FFFF;
    bus.iss_valid = 1; bus.iss_wa = 0;
    cycle();
    idle();
    set_ra_all(5'd0);
    bus.dbg_rf_ra = 5'd0;
    #1;
    chk("r0_rd", bus.rf_rd, '0);
    chk("r0_dbg", bus.dbg_rf_rd, '0);
    chk("r0_cnt", bus.busy_cnt, '0);

    // Single write, visible on every read port
    bus.rf_we0 = 1; bus.rf_wa0 = 3; bus.rf_wd0 = 32'h1234;
    cycle();
    idle();
    set_ra_all(5'd3);
    #1;
    chk("w3_rd0", bus.rf_rd[0 +: DW], 32'h1234);
    chk("w3_rd1", bus.rf_rd[DW +: DW], 32'h1234);

    // Same-address double write: port 1 wins
    bus.rf_we0 = 1; bus.rf_wa0 = 7; bus.rf_wd0 = 32'hAAAA;
    bus.rf_we1 = 1; bus.rf_wa1 = 7; bus.rf_wd1 = 32'h5555;
    cycle();
    idle();
    set_ra_all(5'd7);
    #1;
    chk("w7_rd", bus.rf_rd[0 +: DW], 32'h5555);
    cycle();

    // Set beats clear on the same register
    bus.iss_valid = 1; bus.iss_wa = 5;
    cycle();
    bus.rf_we0 = 1; bus.rf_wa0 = 5; bus.rf_wd0 = 32'h10;
    cycle();
    idle();
    set_ra_all(5'd5);
    #1;
    chk("b5_busy", bus.rf_busy[0], 1'b1);
    chk("b5_cnt", bus.busy_cnt, 6'd1);
    chk("b5_rd", bus.rf_rd[DW +: DW], 32'h10);
    cycle();

    // Bypass behaviour on a fresh register
    bus.rf_we0 = 1; bus.rf_wa0 = 9; bus.rf_wd0 = 32'h1;
    cycle();
    bus.rf_wd0 = 32'hBEEF;
    bus.rf_ra[0 +: AW] = 5'd9;
    bus.dbg_rf_ra = 5'd9;
    #1;
`ifdef RF_BYPASS_EN
    chk("byp_rd", bus.rf_rd[0 +: DW], 32'hBEEF);
`else
    chk("byp_rd", bus.rf_rd[0 +: DW], 32'h1);
`endif
    chk("byp_dbg_pre", bus.dbg_rf_rd, 32'h1);
    cycle();
    idle();
    chk("byp_dbg_post", bus.dbg_rf_rd, 32'hBEEF);
    cycle();

    // Randomized traffic, addresses biased to collide
    for (int n = 0; n < 400; n++) begin
      bus.rf_we0    = 1'($urandom_range(0, 1));
      bus.rf_wa0    = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      bus.rf_wd0    = $urandom;
      bus.rf_we1    = 1'($urandom_range(0, 1));
      bus.rf_wa1    = 5'($urandom_range(0, 7));
      bus.rf_wd1    = $urandom;
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_wa    = 5'($urandom_range(0, 7));
      for (int k = 0; k < NR; k++) bus.rf_ra[k*AW +: AW] = 5'($urandom_range(0, 8));
      bus.dbg_rf_ra = 5'($urandom_range(0, 31));
      cycle();
    end

    // Clean slate, fill and issue 1..4, then async reset between edges
    rstn = 1'b0;
    idle();
    cycle();
    rstn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.rf_we0 = 1; bus.rf_wa0 = 5'(i); bus.rf_wd0 = 32'(i * 32'h11);
      bus.iss_valid = 1; bus.iss_wa = 5'(i);
      cycle();
    end
    idle();
    bus.rf_ra[0 +: AW] = 5'd1;
    bus.rf_ra[AW +: AW] = 5'd4;
    bus.dbg_rf_ra = 5'd2;
    #1;
    chk("fill_cnt", bus.busy_cnt, 6'd4);
    chk("fill_rd1", bus.rf_rd[AW*0 +: DW], 32'h11);
    rstn = 1'b0;
    bus.rf_we0 = 1; bus.rf_wa0 = 2; bus.rf_wd0 = 32'hDEAD;
    #1;
    chk("arst_rd", bus.rf_rd, '0);
    chk("arst_busy", bus.rf_busy, '0);
    chk("arst_cnt", bus.busy_cnt, '0);
    chk("arst_dbg", bus.dbg_rf_rd, '0);
    cycle();
    rstn = 1'b1;
    idle();
    cycle();
    chk("arst_discard", bus.dbg_rf_rd, '0);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
